// File: rtl/music_pkg.sv
// Shared types and constants for the music playback sequencer.
// Sequencer states, rest/terminator code and default bus widths.
package music_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } seq_state_t;

  localparam int NOTE_REST  = 0;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NOTE_W = 8;

endpackage

// File: rtl/music_sequencer_beat_timer.sv
// Beat timer: counts enabled cycles, wraps at TICKS-1.
// tc flags the terminal count so the sequencer can advance.
module beat_timer
  import music_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] count;

  assign tc = (count == CW'(TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Note ROM playback controller: start/pause/stop/end-of-song.
// Define MUSIC_SEQ_LOOP_EN to wrap to address 0 instead of DONE.
module music_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_TICKS = 12500000,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int SONG_LEN   = 241
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              beat,
  output logic              playing,
  output logic              done
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [NOTE_W-1:0] note_d;
  logic              valid_d;
  logic              beat_d;
  logic              refetch_q, refetch_d;
  logic              cnt_en, cnt_clr, tc;
  logic              song_end;

  beat_timer #(.TICKS(BEAT_TICKS)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .tc   (tc)
  );

  assign song_end = (rom_note == NOTE_W'(NOTE_REST))
                 || (rom_addr == ADDR_W'(SONG_LEN));
  assign playing  = (state_q == S_FETCH)
                 || (state_q == S_LATCH)
                 || (state_q == S_PLAY);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    addr_d    = rom_addr;
    note_d    = note_out;
    valid_d   = note_valid;
    beat_d    = 1'b0;
    refetch_d = refetch_q;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    if (stop) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      note_d    = '0;
      valid_d   = 1'b0;
      refetch_d = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !pause) begin
            state_d = S_FETCH;
            addr_d  = '0;
            cnt_clr = 1'b1;
          end
        end
        S_FETCH: begin
          if (pause) begin
            state_d   = S_PAUSED;
            valid_d   = 1'b0;
            refetch_d = 1'b1;
          end else begin
            state_d = S_LATCH;
          end
        end
        S_LATCH: begin
          if (pause) begin
            state_d   = S_PAUSED;
            valid_d   = 1'b0;
            refetch_d = 1'b1;
          end else if (song_end) begin
`ifdef MUSIC_SEQ_LOOP_EN
            state_d = S_FETCH;
            addr_d  = '0;
`else
            state_d = S_DONE;
            note_d  = '0;
            valid_d = 1'b0;
`endif
          end else begin
            state_d = S_PLAY;
            note_d  = rom_note;
            valid_d = 1'b1;
            beat_d  = 1'b1;
          end
        end
        S_PLAY: begin
          if (pause) begin
            state_d   = S_PAUSED;
            valid_d   = 1'b0;
            refetch_d = 1'b0;
          end else begin
            cnt_en = 1'b1;
            if (tc) begin
              state_d = S_FETCH;
              addr_d  = rom_addr + ADDR_W'(1);
            end
          end
        end
        S_PAUSED: begin
          // a pause caught before the note latched must re-read the ROM
          if (!pause && start) begin
            refetch_d = 1'b0;
            if (refetch_q) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_PLAY;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rom_addr   <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      beat       <= 1'b0;
      refetch_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr   <= addr_d;
      note_out   <= note_d;
      note_valid <= valid_d;
      beat       <= beat_d;
      refetch_q  <= refetch_d;
    end
  end

endmodule
